// File: rtl/regread_stage.sv
// Register-read issue stage: in-order input FIFO with a bypass path, a
// multi-port register file, and a registered output that picks up late commit writes.
module regread_stage #(
  parameter int unsigned REG_W    = 7,
  parameter int unsigned VAL_W    = 32,
  parameter int unsigned CTRL_W   = 16,
  parameter int unsigned META_W   = 103,
  parameter int unsigned WR_PORTS = 2,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_W-1:0]          in_src1,
  input  logic [REG_W-1:0]          in_src2,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [META_W-1:0]         in_meta,
  input  logic [WR_PORTS-1:0]       wr_en,
  input  logic [WR_PORTS*REG_W-1:0] wr_reg,
  input  logic [WR_PORTS*VAL_W-1:0] wr_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_W-1:0]          out_src1,
  output logic [REG_W-1:0]          out_src2,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [META_W-1:0]         out_meta,
  output logic [VAL_W-1:0]          out_val1,
  output logic [VAL_W-1:0]          out_val2,
  output logic [$clog2(DEPTH):0]    buf_count
);

  localparam int unsigned NREG = 1 << REG_W;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;

  logic [VAL_W-1:0]  rf     [NREG];
  logic [REG_W-1:0]  q_src1 [DEPTH];
  logic [REG_W-1:0]  q_src2 [DEPTH];
  logic [CTRL_W-1:0] q_ctrl [DEPTH];
  logic [META_W-1:0] q_meta [DEPTH];
  logic [PW-1:0]     head, tail;

  logic              accept, load, deq, bypass, enq;
  logic [REG_W-1:0]  sel_src1, sel_src2;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [META_W-1:0] sel_meta;
  logic [VAL_W-1:0]  rd_val1, rd_val2, hold_val1, hold_val2;

  // Value of idx as seen this cycle: highest matching write port, else base.
  function automatic logic [VAL_W-1:0] fwd(
    input logic [REG_W-1:0]          idx,
    input logic [VAL_W-1:0]          base,
    input logic [WR_PORTS-1:0]       en,
    input logic [WR_PORTS*REG_W-1:0] regs,
    input logic [WR_PORTS*VAL_W-1:0] vals
  );
    logic [VAL_W-1:0] v;
    v = base;
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      if (en[p] && (regs[p*REG_W +: REG_W] == idx) && (idx != '0)) begin
        v = vals[p*VAL_W +: VAL_W];
      end
    end
    return v;
  endfunction

  always_comb begin
    in_ready = ~flush & (buf_count < CW'(DEPTH));
    accept   = in_valid & in_ready;
    load     = (~out_valid | out_ready) & ~flush;
    deq      = load & (buf_count != '0);
    bypass   = load & (buf_count == '0) & accept;
    enq      = accept & ~bypass;
    sel_src1 = deq ? q_src1[head] : in_src1;
    sel_src2 = deq ? q_src2[head] : in_src2;
    sel_ctrl = deq ? q_ctrl[head] : in_ctrl;
    sel_meta = deq ? q_meta[head] : in_meta;
    rd_val1   = fwd(sel_src1, rf[sel_src1], wr_en, wr_reg, wr_val);
    rd_val2   = fwd(sel_src2, rf[sel_src2], wr_en, wr_reg, wr_val);
    hold_val1 = fwd(out_src1, out_val1, wr_en, wr_reg, wr_val);
    hold_val2 = fwd(out_src2, out_val2, wr_en, wr_reg, wr_val);
  end

  // Register file; later ports overwrite earlier ones on the same index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREG; r++) rf[r] <= '0;
    end else begin
      for (int unsigned p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && (wr_reg[p*REG_W +: REG_W] != '0)) begin
          rf[wr_reg[p*REG_W +: REG_W]] <= wr_val[p*VAL_W +: VAL_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_src1[tail] <= in_src1;
      q_src2[tail] <= in_src2;
      q_ctrl[tail] <= in_ctrl;
      q_meta[tail] <= in_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
    end else begin
      head      <= head + PW'(deq);
      tail      <= tail + PW'(enq);
      buf_count <= buf_count + CW'(enq) - CW'(deq);
    end
  end

  // Output register: load from FIFO head or bypass, otherwise track commits while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_src1  <= '0;
      out_src2  <= '0;
      out_ctrl  <= '0;
      out_meta  <= '0;
      out_val1  <= '0;
      out_val2  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (load) begin
      if (deq || bypass) begin
        out_valid <= 1'b1;
        out_src1  <= sel_src1;
        out_src2  <= sel_src2;
        out_ctrl  <= sel_ctrl;
        out_meta  <= sel_meta;
        out_val1  <= rd_val1;
        out_val2  <= rd_val2;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end else begin
      out_val1 <= hold_val1;
      out_val2 <= hold_val2;
    end
  end

endmodule

// File: tb/tb_regread_stage.sv
// Scoreboard bench for regread_stage: a driver records accepted instructions and
// architectural register state; a negedge monitor checks every presented output.
module tb_regread_stage;
  localparam int unsigned REG_W = 7, VAL_W = 32, CTRL_W = 16, META_W = 103;
  localparam int unsigned WR_PORTS = 2, DEPTH = 4;

  logic                      clk, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [REG_W-1:0]          in_src1, in_src2, out_src1, out_src2;
  logic [CTRL_W-1:0]         in_ctrl, out_ctrl;
  logic [META_W-1:0]         in_meta, out_meta;
  logic [WR_PORTS-1:0]       wr_en;
  logic [WR_PORTS*REG_W-1:0] wr_reg;
  logic [WR_PORTS*VAL_W-1:0] wr_val;
  logic [VAL_W-1:0]          out_val1, out_val2;
  logic [$clog2(DEPTH):0]    buf_count;

  typedef struct {
    logic [REG_W-1:0]  s1, s2;
    logic [CTRL_W-1:0] c;
    logic [META_W-1:0] m;
  } item_t;

  item_t            exp_q[$];
  logic [VAL_W-1:0] mrf [1 << REG_W];
  int               n_cmp = 0, n_bad = 0;
  bit               mon_en = 0;

  regread_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_src1(in_src1), .in_src2(in_src2),
    .in_ctrl(in_ctrl), .in_meta(in_meta),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_val(wr_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_src1(out_src1), .out_src2(out_src2),
    .out_ctrl(out_ctrl), .out_meta(out_meta), .out_val1(out_val1), .out_val2(out_val2),
    .buf_count(buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: output state must match the model of accepted-but-not-consumed work.
  always @(negedge clk) begin
    int    sz;
    int    exp_cnt;
    item_t e;
    if (mon_en && reset_n) begin
      sz      = exp_q.size();
      exp_cnt = (sz > 0) ? sz - 1 : 0;
      chk("mon_valid", out_valid, sz > 0);
      chk("mon_count", buf_count, exp_cnt);
      chk("mon_in_ready", in_ready, !flush && (exp_cnt < int'(DEPTH)));
      if (!out_valid) begin
        chk("mon_idle_ctrl", out_ctrl, 0);
      end else begin
        chk("mon_val1", out_val1, mrf[out_src1]);
        chk("mon_val2", out_val2, mrf[out_src2]);
      end
      if (out_valid && out_ready && sz > 0) begin
        e = exp_q.pop_front();
        chk("mon_src1", out_src1, e.s1);
        chk("mon_src2", out_src2, e.s2);
        chk("mon_ctrl", out_ctrl, e.c);
        chk("mon_meta", out_meta, e.m);
      end
    end
  end

  // Called late in the cycle: capture this cycle's handshake, flush and commits into the model.
  task automatic record();
    item_t it;
    if (in_valid && in_ready) begin
      it.s1 = in_src1; it.s2 = in_src2; it.c = in_ctrl; it.m = in_meta;
      exp_q.push_back(it);
    end
    if (flush) exp_q.delete();
    for (int p = 0; p < int'(WR_PORTS); p++) begin
      if (wr_en[p] && wr_reg[p*REG_W +: REG_W] != '0)
        mrf[wr_reg[p*REG_W +: REG_W]] = wr_val[p*VAL_W +: VAL_W];
    end
  endtask

  task automatic tick();
    #6;
    record();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wr_en = '0;
  endtask

  task automatic wr(input int p, input logic [REG_W-1:0] r, input logic [VAL_W-1:0] v);
    wr_en[p] = 1'b1;
    wr_reg[p*REG_W +: REG_W] = r;
    wr_val[p*VAL_W +: VAL_W] = v;
  endtask

  task automatic push(input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
                      input logic [CTRL_W-1:0] c);
    idle();
    in_valid = 1'b1; in_src1 = s1; in_src2 = s2; in_ctrl = c;
    in_meta = META_W'({$urandom, $urandom, $urandom, $urandom});
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << REG_W); i++) mrf[i] = '0;
    reset_n = 1'b0; out_ready = 1'b0; idle();
    in_src1 = '0; in_src2 = '0; in_ctrl = '0; in_meta = '0; wr_reg = '0; wr_val = '0;
    #23 reset_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", buf_count, 0);
    chk("rst_ctrl", out_ctrl, 0);
    mon_en = 1;
    @(posedge clk); #2;

    // Written value is forwarded to a later issue; index 0 reads zero.
    out_ready = 1'b1; idle(); wr(0, 7'd5, 32'hAA); tick();
    push(7'd5, 7'd0, 16'h0101);
    idle();
    chk("fwd_valid", out_valid, 1);
    chk("fwd_val1", out_val1, 32'hAA);
    chk("fwd_val2", out_val2, 32'h0);
    tick();

    // Same-cycle writes to one index: highest port wins.
    idle(); in_valid = 1'b1; in_src1 = 7'd9; in_src2 = 7'd0; in_ctrl = 16'h0202;
    wr(0, 7'd9, 32'h11); wr(1, 7'd9, 32'h22); tick();
    idle();
    chk("prio_val1", out_val1, 32'h22);
    tick();

    // Fill output plus FIFO under backpressure, then drain in order.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(7'(k + 1), 7'd0, 16'(32'h10 + k));
    idle();
    chk("full_count", buf_count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_order", out_ctrl, 16'(32'h10 + k));
      tick();
    end
    chk("drain_empty", out_valid, 0);

    // Stalled output picks up a commit to its source register.
    out_ready = 1'b0;
    push(7'd0, 7'd7, 16'h0303);
    idle(); wr(0, 7'd7, 32'h33);
    chk("stall_before", out_val2, 32'h0);
    tick();
    idle();
    chk("stall_val2", out_val2, 32'h33);
    chk("stall_valid", out_valid, 1);
    out_ready = 1'b1; tick();

    // Flush with three buffered: everything dropped, concurrent write survives.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(7'd1, 7'd2, 16'(32'h20 + k));
    idle();
    chk("pre_flush_count", buf_count, 3);
    flush = 1'b1; in_valid = 1'b1; in_src1 = 7'd3; in_ctrl = 16'h0999; wr(0, 7'd3, 32'h44);
    tick();
    idle();
    chk("flush_count", buf_count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    out_ready = 1'b1;
    push(7'd3, 7'd0, 16'h0404);
    idle();
    chk("flush_wr_kept", out_val1, 32'h44);
    tick();

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(7'd5, 7'd9, 16'(32'h30 + k));
    idle();
    chk("pre_rst_count", buf_count, 2);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", buf_count, 0);
    chk("arst_ctrl", out_ctrl, 0);
    chk("arst_val1", out_val1, 0);
    chk("arst_meta", out_meta, 0);
    exp_q.delete();
    for (int i = 0; i < (1 << REG_W); i++) mrf[i] = '0;
    #3 reset_n = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b1;
    push(7'd5, 7'd9, 16'h0505);
    idle();
    chk("arst_file_p5", out_val1, 32'h0);
    chk("arst_file_p9", out_val2, 32'h0);
    tick();

    // Randomized traffic with frequent register hits, backpressure and occasional flush.
    for (int n = 0; n < 3000; n++) begin
      idle();
      in_valid  = ($urandom % 4) != 0;
      in_src1   = 7'($urandom_range(0, 15));
      in_src2   = 7'($urandom_range(0, 15));
      in_ctrl   = 16'($urandom);
      in_meta   = META_W'({$urandom, $urandom, $urandom, $urandom});
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      for (int p = 0; p < int'(WR_PORTS); p++) begin
        if ($urandom % 2 == 0) wr(p, 7'($urandom_range(0, 15)), $urandom);
      end
      tick();
    end

    idle(); out_ready = 1'b1;
    repeat (8) tick();
    chk("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regread_stage.md
REGREAD_STAGE -- requirements
Module: regread_stage

Interface
REQ-001 Parameter REG_W, default 7: physical register index width; file holds 2**REG_W entries.
REQ-002 Parameter VAL_W, default 32: register value width.
REQ-003 Parameter CTRL_W, default 16: packed control width; all-zero encodes NOP.
REQ-004 Parameter META_W, default 103: opaque payload (dst reg, pc, immediate), passed through unmodified.
REQ-005 Parameter WR_PORTS, default 2: number of commit write ports, >=1.
REQ-006 Parameter DEPTH, default 4: input buffer entries, power of 2, >=2.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 reset_n  in  1  reset, asynchronous and active-low.
REQ-009 flush  in  1  synchronous pipeline flush.
REQ-010 in_valid  in  1  instruction offered.
REQ-011 in_ready  out  1  stage accepts instruction this cycle.
REQ-012 in_src1  in  REG_W  source physical register 1.
REQ-013 in_src2  in  REG_W  source physical register 2.
REQ-014 in_ctrl  in  CTRL_W  control word.
REQ-015 in_meta  in  META_W  opaque payload.
REQ-016 wr_en  in  WR_PORTS  per-port commit write enable.
REQ-017 wr_reg  in  WR_PORTS*REG_W  per-port write index, port i at bits [i*REG_W +: REG_W].
REQ-018 wr_val  in  WR_PORTS*VAL_W  per-port write value, same packing.
REQ-019 out_valid  out  1  issued instruction valid.
REQ-020 out_ready  in  1  downstream accepts issued instruction.
REQ-021 out_src1 / out_src2  out  REG_W each  registered source indices.
REQ-022 out_ctrl  out  CTRL_W  registered control; zero when out_valid=0.
REQ-023 out_meta  out  META_W  registered payload.
REQ-024 out_val1 / out_val2  out  VAL_W each  operand values.
REQ-025 buf_count  out  $clog2(DEPTH)+1  buffered (not yet issued) entries.

Function
REQ-026 Register file: 2**REG_W x VAL_W; index 0 reads 0, writes to index 0 ignored.
REQ-027 Writes commit at the clock edge for every asserted port; same index on several ports: highest port index wins.
REQ-028 in_ready = ~flush & (buf_count < DEPTH); a handshake occurs when in_valid & in_ready.
REQ-029 Output register loads when (~out_valid | out_ready) & ~flush; source is the FIFO head if buf_count>0, else the accepted input (bypass, 1-cycle latency), else out_valid<=0.
REQ-030 Accepted input not loaded directly is enqueued at the tail; enqueue and dequeue in the same cycle leave buf_count unchanged.
REQ-031 FIFO is full at buf_count=DEPTH: no enqueue even if a dequeue happens the same cycle; pointers wrap modulo DEPTH.
REQ-032 Operands are read when the output register loads: value = highest-index port with wr_en & wr_reg==src & src!=0 this cycle, else file content.
REQ-033 While out_valid & ~out_ready, out_val1/out_val2 update from any same-cycle matching write (same priority); index 0 never updates.
REQ-034 Flush: buf_count<=0, out_valid<=0, out_ctrl<=0, input dropped; file writes still commit.
REQ-035 Ordering: issue order equals acceptance order; no instruction is duplicated or lost absent flush.

Reset
REQ-036 reset_n low asynchronously clears file to 0, buf_count, pointers, out_valid, out_ctrl, out_meta, out_src1/2, out_val1/2 to 0; in_ready=1 after release.
REQ-037 Reset asserted mid-operation discards all buffered and issued instructions immediately.

Verification
REQ-038 Write p5=0xAA, then issue src1=5, src2=0, out_ready=1 -> next cycle out_valid=1, out_val1=0xAA, out_val2=0.
REQ-039 Same cycle: issue src1=9 while port0 writes p9=0x11 and port1 writes p9=0x22 -> out_val1=0x22.
REQ-040 Hold out_ready=0, push 5 instructions -> 1 in output, buf_count=4, in_ready=0; release -> issued in order, one per cycle.
REQ-041 Output stalled with src2=7, write p7=0x33 -> out_val2 becomes 0x33 next cycle while out_valid stays 1.
REQ-042 buf_count=3, assert flush with in_valid=1 -> next cycle buf_count=0, out_valid=0, out_ctrl=0, write during flush visible later.
REQ-043 Drop reset_n mid-cycle with buf_count=2 -> outputs zero immediately, file reads 0 afterwards.
